// File: rtl/gb_cart_pkg.sv
// gb_cart_pkg: cartridge header decoding helpers and backup controller states
package gb_cart_pkg;

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    localparam logic [7:0] MBC2_TYPE      = 8'h05;
    localparam logic [7:0] MBC2_BATT_TYPE = 8'h06;

    function automatic logic has_battery(input logic [7:0] mbc_type);
        return mbc_type inside {8'h03, 8'h06, 8'h09, 8'h0D, 8'h10,
                                8'h13, 8'h1B, 8'h1E, 8'h22, 8'hFF};
    endfunction

    function automatic logic is_mbc2(input logic [7:0] mbc_type);
        return mbc_type inside {MBC2_TYPE, MBC2_BATT_TYPE};
    endfunction

    // MBC2 has 512 half-bytes of internal RAM, saved as one full 1 KB image
    function automatic logic [7:0] ram_last_lba(input logic [7:0] ram_size, input logic mbc2);
        return mbc2              ? 8'd1  :
               ram_size == 8'd1 ? 8'd3  :
               ram_size == 8'd2 ? 8'd15 :
               ram_size == 8'd3 ? 8'd63 : 8'd255;
    endfunction

endpackage

// File: rtl/edge_det.sv
// edge_det: registered rising-edge detector for level request inputs
module edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_prev <= 1'b0;
        else          r_prev <= i_d;
    end

    assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/cram_backup_ctrl.sv
// cram_backup_ctrl: sequences battery-backed cart RAM load/save through the SD sector buffer
module cram_backup_ctrl
    import gb_cart_pkg::*;
#(
    parameter int SECTOR_AW = 9,
    parameter int LBA_W     = 8
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic [7:0]                 cart_mbc_type,
    input  logic [7:0]                 cart_ram_size,
    input  logic                       cart_ram_wr,
    input  logic                       img_mounted,
    input  logic                       img_readonly,
    input  logic                       load_req,
    input  logic                       save_req,
    output logic [31:0]                sd_lba,
    output logic                       sd_rd,
    output logic                       sd_wr,
    input  logic                       sd_ack,
    input  logic [SECTOR_AW-1:0]       sd_buff_addr,
    input  logic                       sd_buff_wr,
    input  logic [7:0]                 sd_buff_dout,
    output logic [7:0]                 sd_buff_din,
    output logic [LBA_W+SECTOR_AW-1:0] bk_addr,
    output logic                       bk_wr,
    output logic [7:0]                 bk_data,
    input  logic [7:0]                 bk_q,
    output logic                       busy,
    output logic                       dirty
);

    state_t             r_state, w_state_n;
    logic [LBA_W-1:0]   r_lba, w_lba_n;
    logic               r_rd, w_rd_n;
    logic               r_wr, w_wr_n;
    logic               r_busy, w_busy_n;
    logic               r_loading, w_loading_n;
    logic               r_dirty, w_dirty_n;
    logic               r_bk_ena;
    logic               w_start_load, w_start_save, w_start;
    logic               w_mbc2, w_supported, w_last_hit;
    logic [7:0]         w_last_lba;

    edge_det u_load_edge (
        .i_clk   (clk_sys),
        .i_rst_n (reset_n),
        .i_d     (load_req),
        .o_rise  (w_start_load)
    );

    edge_det u_save_edge (
        .i_clk   (clk_sys),
        .i_rst_n (reset_n),
        .i_d     (save_req),
        .o_rise  (w_start_save)
    );

    assign w_mbc2      = is_mbc2(cart_mbc_type);
    assign w_last_lba  = ram_last_lba(cart_ram_size, w_mbc2);
    assign w_supported = has_battery(cart_mbc_type) & ((cart_ram_size != 8'd0) | w_mbc2) & r_bk_ena;
    assign w_start     = w_supported & (w_start_load | w_start_save);
    assign w_last_hit  = r_lba == LBA_W'(w_last_lba);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) r_bk_ena <= 1'b0;
        else if (img_mounted) r_bk_ena <= ~img_readonly;
    end

    // Load wins a simultaneous start; a save start clears dirty even against a same-cycle write
    always_comb begin
        w_state_n   = r_state;
        w_lba_n     = r_lba;
        w_rd_n      = r_rd;
        w_wr_n      = r_wr;
        w_busy_n    = r_busy;
        w_loading_n = r_loading;
        w_dirty_n   = r_dirty | cart_ram_wr;
        case (r_state)
            IDLE: if (w_start) begin
                w_state_n   = REQ;
                w_lba_n     = '0;
                w_loading_n = w_start_load;
                w_rd_n      = w_start_load;
                w_wr_n      = ~w_start_load;
                w_busy_n    = 1'b1;
                w_dirty_n   = w_start_load ? w_dirty_n : 1'b0;
            end
            REQ: if (sd_ack) begin
                w_state_n = XFER;
                w_rd_n    = 1'b0;
                w_wr_n    = 1'b0;
            end
            XFER: if (!sd_ack) begin
                if (w_last_hit) begin
                    w_state_n = IDLE;
                    w_busy_n  = 1'b0;
                    w_dirty_n = r_loading ? cart_ram_wr : w_dirty_n;
                end else begin
                    w_state_n = REQ;
                    w_lba_n   = r_lba + LBA_W'(1);
                    w_rd_n    = r_loading;
                    w_wr_n    = ~r_loading;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_lba     <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_loading <= 1'b0;
            r_dirty   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_lba     <= w_lba_n;
            r_rd      <= w_rd_n;
            r_wr      <= w_wr_n;
            r_busy    <= w_busy_n;
            r_loading <= w_loading_n;
            r_dirty   <= w_dirty_n;
        end
    end

    assign sd_lba      = 32'(r_lba);
    assign sd_rd       = r_rd;
    assign sd_wr       = r_wr;
    assign busy        = r_busy;
    assign dirty       = r_dirty;
    assign sd_buff_din = bk_q;
    assign bk_addr     = {r_lba, sd_buff_addr};
    assign bk_wr       = sd_buff_wr & sd_ack & r_loading;
    assign bk_data     = sd_buff_dout;

endmodule

// File: tb/tb_cram_backup_ctrl.sv
// tb_cram_backup_ctrl: scoreboard bench with SD host model, cart RAM model and header-rule reference
module tb_cram_backup_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [7:0]  cart_mbc_type, cart_ram_size;
    logic        cart_ram_wr, img_mounted, img_readonly, load_req, save_req;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_dout, sd_buff_din;
    logic [16:0] bk_addr;
    logic        bk_wr;
    logic [7:0]  bk_data, bk_q;
    logic        busy, dirty;

    int          checks = 0;
    int          failures = 0;
    logic [33:0] sec_q[$];
    logic        done_q[$];
    logic [7:0]  cram [0:131071];
    logic [7:0]  exp_ram [0:131071];
    bit          m_dirty, m_ena;

    always #5 clk_sys = ~clk_sys;

    cram_backup_ctrl dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .cart_mbc_type (cart_mbc_type),
        .cart_ram_size (cart_ram_size),
        .cart_ram_wr   (cart_ram_wr),
        .img_mounted   (img_mounted),
        .img_readonly  (img_readonly),
        .load_req      (load_req),
        .save_req      (save_req),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_addr  (sd_buff_addr),
        .sd_buff_wr    (sd_buff_wr),
        .sd_buff_dout  (sd_buff_dout),
        .sd_buff_din   (sd_buff_din),
        .bk_addr       (bk_addr),
        .bk_wr         (bk_wr),
        .bk_data       (bk_data),
        .bk_q          (bk_q),
        .busy          (busy),
        .dirty         (dirty)
    );

    function automatic logic [7:0] seed_byte(input int a);
        return 8'((a * 37) ^ (a >> 7) ^ 8'hA5);
    endfunction

    function automatic bit m_battery(input logic [7:0] t);
        logic [7:0] list [10] = '{8'h03, 8'h06, 8'h09, 8'h0D, 8'h10, 8'h13, 8'h1B, 8'h1E, 8'h22, 8'hFF};
        for (int i = 0; i < 10; i++) if (list[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_mbc2(input logic [7:0] t);
        return t == 8'h05 || t == 8'h06;
    endfunction

    function automatic int m_sectors();
        if (m_mbc2(cart_mbc_type)) return 2;
        case (cart_ram_size)
            8'd1:    return 4;
            8'd2:    return 16;
            8'd3:    return 64;
            default: return 256;
        endcase
    endfunction

    function automatic bit m_supported();
        return m_battery(cart_mbc_type) && (cart_ram_size != 8'd0 || m_mbc2(cart_mbc_type)) && m_ena;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Cart RAM port B: synchronous write, registered read
    initial begin : ram_model
        for (int a = 0; a < 131072; a++) cram[a] = seed_byte(a);
        forever begin
            @(posedge clk_sys);
            bk_q <= cram[bk_addr];
            if (bk_wr) cram[bk_addr] = bk_data;
        end
    end

    task automatic serve(input logic ld, input logic [7:0] lba);
        int bad = 0;
        repeat ($urandom_range(0, 2)) tick();
        sd_ack = 1'b1;
        for (int a = 0; a < 512 && reset_n; a++) begin
            sd_buff_addr = 9'(a);
            if (ld) begin
                sd_buff_dout = 8'($urandom);
                sd_buff_wr = 1'b1;
                exp_ram[{lba, 9'(a)}] = sd_buff_dout;
            end
            tick();
            if (!ld && sd_buff_din !== exp_ram[{lba, 9'(a)}]) bad++;
        end
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        if (!ld && reset_n) chk("save_sector_data", 64'(bad), 64'd0);
    endtask

    initial begin : host
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        sd_buff_addr = '0;
        sd_buff_dout = '0;
        for (int a = 0; a < 131072; a++) exp_ram[a] = seed_byte(a);
        forever begin
            tick();
            if (reset_n && (sd_rd || sd_wr) && !sd_ack) serve(sd_rd, sd_lba[7:0]);
        end
    end

    initial begin : monitor
        logic prev_req, prev_busy;
        logic [33:0] e;
        logic d;
        prev_req = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk_sys);
            if ((sd_rd || sd_wr) && !prev_req) begin
                if (sec_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sector_request actual rd=%0b wr=%0b lba=%0d required none", sd_rd, sd_wr, sd_lba);
                end else begin
                    e = sec_q.pop_front();
                    chk("sector_request", 64'({sd_rd, sd_wr, sd_lba}), 64'(e));
                end
            end
            if (prev_busy && !busy) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_event actual busy_fall required none");
                end else begin
                    d = done_q.pop_front();
                    chk("done_dirty", 64'(dirty), 64'(d));
                end
            end
            prev_req = sd_rd || sd_wr;
            prev_busy = busy;
        end
    end

    task automatic mount(input bit ro);
        img_readonly = ro;
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        img_readonly = 1'b0;
        m_ena = !ro;
    endtask

    task automatic gb_write();
        cart_ram_wr = 1'b1;
        tick();
        cart_ram_wr = 1'b0;
        m_dirty = 1'b1;
    endtask

    task automatic wait_lba(input int lba, input bit on_ack);
        int t = 0;
        while (!(sd_lba == 32'(lba) && (on_ack ? sd_ack : (sd_rd || sd_wr))) && t < 20000) begin
            tick();
            t++;
        end
        if (t >= 20000) begin
            checks++;
            failures++;
            $display("FAIL wait_lba actual lba=%0d required lba=%0d", sd_lba, lba);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 40000) begin
            tick();
            t++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL wait_idle actual busy=1 required busy=0");
        end
    endtask

    task automatic run_op(input bit ld, input bit sv, input int wr_lba, input bit extra_save);
        bit acc;
        int n, bad;
        acc = m_supported() && (ld || sv);
        n = m_sectors();
        if (acc) begin
            for (int i = 0; i < n; i++) sec_q.push_back({ld, !ld, 32'(i)});
            done_q.push_back(!ld && wr_lba >= 0);
        end
        load_req = ld;
        save_req = sv;
        tick();
        tick();
        load_req = 1'b0;
        save_req = 1'b0;
        chk("busy_start", 64'(busy), 64'(acc));
        if (acc && !ld) chk("dirty_clear_on_save", 64'(dirty), 64'd0);
        if (extra_save) begin
            repeat (4) tick();
            save_req = 1'b1;
            tick();
            tick();
            save_req = 1'b0;
        end
        if (acc && !ld && wr_lba >= 0) begin
            wait_lba(wr_lba, 1'b1);
            gb_write();
        end
        wait_idle();
        if (acc) m_dirty = ld ? 1'b0 : (wr_lba >= 0);
        chk("dirty_after_op", 64'(dirty), 64'(m_dirty));
        if (acc && ld) begin
            bad = 0;
            for (int a = 0; a < n * 512; a++) if (cram[a] !== exp_ram[a]) bad++;
            chk("load_image", 64'(bad), 64'd0);
        end
        repeat (3) tick();
    endtask

    initial begin : main
        logic [7:0] types [8] = '{8'h01, 8'h03, 8'h05, 8'h06, 8'h13, 8'h1B, 8'h19, 8'hFF};
        int op;
        bit ld, sv;
        reset_n = 1'b0;
        cart_mbc_type = 8'h00;
        cart_ram_size = 8'h00;
        cart_ram_wr = 1'b0;
        img_mounted = 1'b0;
        img_readonly = 1'b0;
        load_req = 1'b0;
        save_req = 1'b0;
        m_dirty = 1'b0;
        m_ena = 1'b0;
        repeat (3) tick();
        chk("reset_sd_rd", 64'(sd_rd), 64'd0);
        chk("reset_sd_wr", 64'(sd_wr), 64'd0);
        chk("reset_sd_lba", 64'(sd_lba), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_dirty", 64'(dirty), 64'd0);
        reset_n = 1'b1;
        tick();

        cart_mbc_type = 8'h03;
        cart_ram_size = 8'h02;
        mount(1'b0);
        gb_write();
        chk("dirty_set_by_write", 64'(dirty), 64'd1);
        run_op(1'b1, 1'b0, -1, 1'b0);

        cart_mbc_type = 8'h13;
        cart_ram_size = 8'h03;
        gb_write();
        run_op(1'b0, 1'b1, -1, 1'b0);

        gb_write();
        cart_mbc_type = 8'h01;
        cart_ram_size = 8'h02;
        run_op(1'b0, 1'b1, -1, 1'b0);
        cart_mbc_type = 8'h03;
        mount(1'b1);
        run_op(1'b0, 1'b1, -1, 1'b0);

        mount(1'b0);
        cart_ram_size = 8'h01;
        run_op(1'b1, 1'b1, -1, 1'b1);

        cart_mbc_type = 8'h06;
        cart_ram_size = 8'h00;
        run_op(1'b0, 1'b1, 1, 1'b0);

        cart_mbc_type = 8'h03;
        cart_ram_size = 8'h02;
        for (int i = 0; i < 6; i++) sec_q.push_back({1'b1, 1'b0, 32'(i)});
        done_q.push_back(1'b0);
        load_req = 1'b1;
        tick();
        tick();
        load_req = 1'b0;
        wait_lba(5, 1'b0);
        reset_n = 1'b0;
        tick();
        chk("abort_sd_rd", 64'(sd_rd), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sd_lba", 64'(sd_lba), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        m_dirty = 1'b0;
        m_ena = 1'b0;
        repeat (5) tick();
        run_op(1'b1, 1'b0, -1, 1'b0);
        mount(1'b0);
        run_op(1'b1, 1'b0, -1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            cart_mbc_type = types[$urandom_range(0, 7)];
            cart_ram_size = 8'($urandom_range(0, 1));
            mount($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) gb_write();
            op = $urandom_range(0, 2);
            ld = op != 1;
            sv = op != 0;
            run_op(ld, sv, (!ld && $urandom_range(0, 1) == 1) ? 0 : -1, 1'b0);
        end

        chk("sector_queue_drained", 64'(sec_q.size()), 64'd0);
        chk("done_queue_drained", 64'(done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cram_backup_ctrl.md
Name: cram_backup_ctrl

Overview:
Sequences battery-backed cartridge RAM load/save between the cart RAM's second port and the SD sector-buffer interface. Owns the cart RAM backup port, issues 512-byte sector read/write requests, and tracks a dirty flag from Game Boy RAM writes. Sits beside `mbc`. It consumes the cart header flags and the cart RAM write strobe, and drives the cart RAM port B and the SD block handshake.

Parameters:
SECTOR_AW, 9, byte-address width within one SD sector (512 B)
LBA_W, 8, sector index width; 256 sectors covers 128 KB cart RAM

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
cart_mbc_type  in  8  header MBC type byte
cart_ram_size  in  8  header RAM size byte
cart_ram_wr  in  1  one-cycle strobe: Game Boy wrote cart RAM
img_mounted  in  1  pulse: save image mounted
img_readonly  in  1  mounted image is read-only (sampled with img_mounted)
load_req  in  1  level: request load (edge-detected)
save_req  in  1  level: request save (edge-detected)
sd_lba  out  32  sector number, zero-extended from LBA_W bits
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
sd_ack  in  1  high while the host transfers the sector
sd_buff_addr  in  SECTOR_AW  byte index in the current sector
sd_buff_wr  in  1  host writes sd_buff_dout (load)
sd_buff_dout  in  8  load data
sd_buff_din  out  8  save data, equals bk_q
bk_addr  out  17  cart RAM port B address = {sd_lba[7:0], sd_buff_addr}
bk_wr  out  1  cart RAM port B write = sd_buff_wr & sd_ack & loading
bk_data  out  8  = sd_buff_dout
bk_q  in  8  cart RAM port B read data (1-cycle latency)
busy  out  1  transfer in progress; top level pauses the Game Boy
dirty  out  1  cart RAM modified since last save or load

Behaviour:
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, busy=0, dirty=0, bk_ena=0, state=IDLE.
- battery = mbc_type ∈ {03,06,09,0D,10,13,1B,1E,22,FF}.
- mbc2 = mbc_type ∈ {05,06}.
- last_lba: mbc2→1; ram_size 1→3; 2→15; 3→63; else→255.
- supported = battery & (ram_size≠0 | mbc2) & bk_ena.
- bk_ena is set on img_mounted & ~img_readonly. It is cleared on img_mounted & img_readonly.
- Edge detection: start_load = rising edge of load_req; start_save = rising edge of save_req. A request that is not supported is dropped. Any request while busy is dropped. If both start in the same cycle, load wins.
- State IDLE → REQ on start: sd_lba=0, loading=start_load, busy=1. When a save starts, dirty is cleared.
- REQ: hold sd_rd=loading and sd_wr=~loading until the cycle after sd_ack rises, then clear both and go to XFER.
- XFER: wait for sd_ack to fall. Then:
  - if sd_lba[7:0]==last_lba: go to IDLE, busy=0; after a load, clear dirty.
  - else: increment sd_lba and return to REQ in the next cycle.
- Save data path: sd_buff_din = bk_q with one-cycle RAM latency. The host presents the address one cycle before it samples data.
- dirty is set by cart_ram_wr in any state except the cycle of a save start. During a save, a Game Boy write re-sets dirty.
- reset_n low mid-transfer: synchronously returns to IDLE, deasserts sd_rd/sd_wr, clears busy. The host's ack is ignored.
- sd_ack glitch while IDLE: no state change; bk_wr stays masked by loading=0.
- sd_lba upper bits [31:LBA_W] are always 0.

Decomposition:
- Package gb_cart_pkg: MBC type constants, battery-type list, function `ram_last_lba(ram_size, mbc2)`, state enum {IDLE, REQ, XFER}.
- Sub-module `edge_det` (1-bit rising-edge detector), instantiated for load_req and save_req.

Test Plan:
1. mbc_type=03, ram_size=02, mount rw, pulse load_req, model host ack per sector → exactly 16 sd_rd handshakes, LBA 0..15. bk_wr writes 8192 bytes to bk_addr 0..0x1FFF, then busy=0 and dirty=0.
2. mbc_type=13, ram_size=03, cart_ram_wr pulse, save_req → dirty clears at start, 64 sd_wr sectors, sd_buff_din matches preloaded RAM, busy falls after LBA 63.
3. mbc_type=01 (no battery) or image read-only, save_req → no sd_wr, busy stays 0.
4. load_req and save_req rise in the same cycle → load executes (sd_rd=1, sd_wr=0). A second save_req during busy is ignored.
5. mbc2 (type 06, ram_size 0) save → 2 sectors. A cart_ram_wr during sector 1 leaves dirty=1 at completion.
6. reset_n low during sector 5 of a load → next cycle sd_rd=0, busy=0, state IDLE. A later load restarts at LBA 0.
